cia_access_sched: RTL and testbench

CIA_ACCESS_SCHED -- requirements
Module: cia_access_sched

---
 rtl/cia_access_sched.sv | 155 +++++++++++++++
 tb/tb_cia_access_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cia_access_sched.sv
// Arbitrates the single CIA register port between the CPU (priority) and a host requester.
// Optional macro CIA_SCHED_TIMEOUT_EN bounds the host wait to TIMEOUT Phi2 cycles.
module cia_access_sched #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_p,
    input  logic       phi2_n,
    input  logic       cpu_cs_n,
    input  logic       cpu_rw,
    input  logic [3:0] cpu_rs,
    input  logic [7:0] cpu_db,
    output logic       cpu_conflict,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [3:0] host_rs,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic       host_err,
    output logic [7:0] host_rdata,
    output logic       cia_cs_n,
    output logic       cia_rw,
    output logic [3:0] cia_rs,
    output logic [7:0] cia_db_in,
    input  logic [7:0] cia_db_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        OWN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        lat_we_r;
    logic [3:0]  lat_rs_r;
    logic [7:0]  lat_wdata_r;
    logic        ack_r;
    logic        err_r;
    logic        conflict_r;
    logic [7:0]  rdata_r;
    logic        tmo_hit_s;
    logic        own_s;

`ifdef CIA_SCHED_TIMEOUT_EN
    localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);
    logic [7:0] tmo_cnt_r;

    // Counts CPU-held Phi2 slots while waiting; zero whenever not pending.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_r != PEND) begin
            tmo_cnt_r <= 8'd0;
        end else if (phi2_p) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; acceptance is held off during the ack clock.
    always_comb begin
        next_state_s = state_r;
        tmo_hit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (host_req && !ack_r) begin
                    next_state_s = PEND;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PEND: begin
                if (phi2_p && cpu_cs_n) begin
                    next_state_s = OWN;
`ifdef CIA_SCHED_TIMEOUT_EN
                end else if (phi2_p && (({1'b0, tmo_cnt_r} + 9'd1) == TMO_LIM)) begin
                    next_state_s = IDLE;
                    tmo_hit_s    = 1'b1;
`endif
                end else begin
                    next_state_s = PEND;
                end
            end
            OWN: begin
                if (phi2_n) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = OWN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // CIA port mux; reset returns the port to the CPU without waiting for an edge.
    always_comb begin
        own_s = (state_r == OWN) && res_n;
        if (own_s) begin
            cia_cs_n  = 1'b0;
            cia_rw    = ~lat_we_r;
            cia_rs    = lat_rs_r;
            cia_db_in = lat_wdata_r;
        end else begin
            cia_cs_n  = cpu_cs_n;
            cia_rw    = cpu_rw;
            cia_rs    = cpu_rs;
            cia_db_in = cpu_db;
        end
    end

    // Host request latch, read capture and single-clock status pulses.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            lat_we_r    <= 1'b0;
            lat_rs_r    <= 4'd0;
            lat_wdata_r <= 8'd0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            conflict_r  <= 1'b0;
            rdata_r     <= 8'h00;
        end else begin
            ack_r      <= (state_r == DONE) || tmo_hit_s;
            err_r      <= tmo_hit_s;
            conflict_r <= (state_r == OWN) && phi2_n && !cpu_cs_n;
            if ((state_r == IDLE) && (next_state_s == PEND)) begin
                lat_we_r    <= host_we;
                lat_rs_r    <= host_rs;
                lat_wdata_r <= host_wdata;
            end
            if ((state_r == DONE) && !lat_we_r) begin
                rdata_r <= cia_db_out;
            end
        end
    end

    assign host_ack     = ack_r;
    assign host_err     = err_r;
    assign cpu_conflict = conflict_r;
    assign host_rdata   = rdata_r;

endmodule

// File: tb/tb_cia_access_sched.sv
// Directed bench for cia_access_sched: stimulus pushes expected host responses,
// a negedge monitor pops and compares them whenever host_ack is presented.
module tb_cia_access_sched;

    logic       clk = 1'b0;
    logic       res_n, phi2_p, phi2_n;
    logic       cpu_cs_n, cpu_rw;
    logic [3:0] cpu_rs;
    logic [7:0] cpu_db;
    logic       cpu_conflict;
    logic       host_req, host_we;
    logic [3:0] host_rs;
    logic [7:0] host_wdata;
    logic       host_ack, host_err;
    logic [7:0] host_rdata;
    logic       cia_cs_n, cia_rw;
    logic [3:0] cia_rs;
    logic [7:0] cia_db_in, cia_db_out;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int conflict_cnt = 0;
    int snap;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    cia_access_sched #(.TIMEOUT(4)) dut (
        .clk(clk), .res_n(res_n), .phi2_p(phi2_p), .phi2_n(phi2_n),
        .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_db(cpu_db),
        .cpu_conflict(cpu_conflict),
        .host_req(host_req), .host_we(host_we), .host_rs(host_rs), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_db_in(cia_db_in),
        .cia_db_out(cia_db_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ack must match the oldest expected {err, rdata}.
    always @(negedge clk) begin
        if (res_n === 1'b1) begin
            if (cpu_conflict === 1'b1) conflict_cnt++;
            if (host_ack === 1'b1) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(host_ack), 32'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("ack_err", 32'(host_err), 32'(e[8]));
                    chk("ack_rdata", 32'(host_rdata), 32'(e[7:0]));
                end
            end else if (host_err === 1'b1) begin
                chk("err_without_ack", 32'(host_err), 32'd0);
            end
        end
    end

    // Launch a single-clock host request.
    task automatic request(input logic we, input logic [3:0] rs, input logic [7:0] wd);
        host_req = 1'b1; host_we = we; host_rs = rs; host_wdata = wd;
        step();
        host_req = 1'b0;
    endtask

    task automatic phi2_cycle();
        phi2_p = 1'b1; step(); phi2_p = 1'b0;
        step(); step();
        phi2_n = 1'b1; step(); phi2_n = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        res_n = 1'b0; phi2_p = 1'b0; phi2_n = 1'b0;
        cpu_cs_n = 1'b0; cpu_rw = 1'b1; cpu_rs = 4'h7; cpu_db = 8'h33;
        host_req = 1'b0; host_we = 1'b0; host_rs = 4'h0; host_wdata = 8'h00;
        cia_db_out = 8'h81;

        // Reset state and passthrough
        step(); step(); step();
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_err", 32'(host_err), 32'd0);
        chk("rst_conflict", 32'(cpu_conflict), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'h00);
        chk("rst_pass_cs", 32'(cia_cs_n), 32'd0);
        chk("rst_pass_rs", 32'(cia_rs), 32'h7);
        chk("rst_pass_db", 32'(cia_db_in), 32'h33);
        res_n = 1'b1; cpu_cs_n = 1'b1;
        step();

        // Host read rs=D; request coincides with phi2_p, which must not grant the slot
        exp_q.push_back({1'b0, 8'h81});
        phi2_p = 1'b1;
        request(1'b0, 4'hD, 8'h00);
        phi2_p = 1'b0;
        step();
        chk("pend_no_own_cs", 32'(cia_cs_n), 32'd1);
        phi2_p = 1'b1; step(); phi2_p = 1'b0;
        chk("read_own_cs", 32'(cia_cs_n), 32'd0);
        chk("read_own_rs", 32'(cia_rs), 32'hD);
        chk("read_own_rw", 32'(cia_rw), 32'd1);
        step();
        phi2_n = 1'b1; step(); phi2_n = 1'b0;
        step(); step();
        chk("read_after_cs", 32'(cia_cs_n), 32'd1);
        chk("read_ack_cnt", 32'(ack_cnt), 32'd1);

        // Host write while the CPU holds three consecutive slots
        cia_db_out = 8'h99;
        cpu_cs_n = 1'b0; cpu_rw = 1'b1; cpu_rs = 4'h2; cpu_db = 8'h11;
        exp_q.push_back({1'b0, 8'h81});
        request(1'b1, 4'h4, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            phi2_p = 1'b1; step(); phi2_p = 1'b0;
            chk("cpu_slot_rs", 32'(cia_rs), 32'h2);
            chk("cpu_slot_db", 32'(cia_db_in), 32'h11);
            step(); step(); step(); step(); step();
        end
        cpu_cs_n = 1'b1;
        phi2_p = 1'b1; step(); phi2_p = 1'b0;
        chk("wr_own_cs", 32'(cia_cs_n), 32'd0);
        chk("wr_own_rw", 32'(cia_rw), 32'd0);
        chk("wr_own_rs", 32'(cia_rs), 32'h4);
        chk("wr_own_db", 32'(cia_db_in), 32'h5A);
        step();
        phi2_n = 1'b1; step(); phi2_n = 1'b0;
        step(); step();
        chk("wr_ack_cnt", 32'(ack_cnt), 32'd2);

        // CPU selects during OWN: conflict pulse, host access wins
        exp_q.push_back({1'b0, 8'h81});
        request(1'b1, 4'h9, 8'hC3);
        phi2_p = 1'b1; step(); phi2_p = 1'b0;
        cpu_cs_n = 1'b0; cpu_rs = 4'h1; cpu_db = 8'h22;
        #1;
        chk("cf_cs", 32'(cia_cs_n), 32'd0);
        chk("cf_rs", 32'(cia_rs), 32'h9);
        chk("cf_db", 32'(cia_db_in), 32'hC3);
        step();
        phi2_n = 1'b1; step(); phi2_n = 1'b0;
        cpu_cs_n = 1'b1;
        step(); step();
        chk("cf_count", 32'(conflict_cnt), 32'd1);
        chk("cf_ack_cnt", 32'(ack_cnt), 32'd3);

        // Reset while OWN: request abandoned, port returns to CPU immediately
        request(1'b0, 4'h5, 8'h00);
        phi2_p = 1'b1; step(); phi2_p = 1'b0;
        chk("rs_own_cs", 32'(cia_cs_n), 32'd0);
        snap = ack_cnt;
        res_n = 1'b0;
        #1;
        chk("rs_pass_cs", 32'(cia_cs_n), 32'd1);
        step();
        res_n = 1'b1;
        phi2_n = 1'b1; step(); phi2_n = 1'b0;
        step(); step(); step();
        chk("rs_no_ack", 32'(ack_cnt - snap), 32'd0);
        chk("rs_rdata", 32'(host_rdata), 32'h00);
        chk("rs_pass_idle", 32'(cia_cs_n), 32'd1);

        // host_req held high: host_rs differs during the ack clock, must not be latched then
        cia_db_out = 8'h42;
        snap = ack_cnt;
        host_req = 1'b1; host_we = 1'b0; host_rs = 4'h3;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 8'h42});
            step();
            phi2_p = 1'b1; step(); phi2_p = 1'b0;
            chk("hold_own_rs", 32'(cia_rs), 32'h3);
            step();
            phi2_n = 1'b1; step(); phi2_n = 1'b0;
            step();
            host_rs = 4'hE;
            step();
            host_rs = 4'h3;
        end
        host_req = 1'b0;
        step(); step();
        chk("hold_ack_cnt", 32'(ack_cnt - snap), 32'd3);

        // CPU holds every slot: timeout behaviour depends on the build
        cpu_cs_n = 1'b0;
        snap = ack_cnt;
        request(1'b0, 4'h6, 8'h00);
`ifdef CIA_SCHED_TIMEOUT_EN
        exp_q.push_back({1'b1, 8'h42});
        for (int i = 0; i < 4; i++) phi2_cycle();
        chk("tmo_ack_cnt", 32'(ack_cnt - snap), 32'd1);
        cpu_cs_n = 1'b1;
`else
        for (int i = 0; i < 6; i++) phi2_cycle();
        chk("no_tmo_ack", 32'(ack_cnt - snap), 32'd0);
        cpu_cs_n = 1'b1;
        exp_q.push_back({1'b0, 8'h42});
        phi2_cycle();
        chk("drain_ack", 32'(ack_cnt - snap), 32'd1);
`endif

        step(); step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
